veryrisc_core_p: RTL and testbench
==================================

# veryrisc_core_p

Parametrised successor to the VeryRISC V accumulator CPU: a single-accumulator machine with a widened 4-bit opcode space, parametrised data/address width, a carry flag, and an external memory port with a req/ack handshake that tolerates any number of wait states. Replaces the free-running phase counter with a state machine whose length depends on the instruction and on memory latency. It sits between the system memory (or a wait-state model) and the top-level halt/run control.

## Interface
- DATA_W, 12, word width; instruction = {opcode[3:0], addr[ADDR_W-1:0]}
- ADDR_W, DATA_W-4, derived (localparam), address width; DATA_W ≥ 8
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- run  in  1  single-cycle pulse; resumes from HALT
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  transaction address
- mem_wdata  out  DATA_W  write data (= acc) while mem_we
- mem_rdata  in  DATA_W  read data, sampled on completing edge
- mem_ack  in  1  transaction completes on edge where mem_req & mem_ack
- halt  out  1  high in HALT state
- pc  out  ADDR_W  program counter (debug)
- acc  out  DATA_W  accumulator (debug)

## Operation
- States: BOOT, FETCH, EXEC, HALT. Reset → BOOT; BOOT → FETCH unconditionally.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ack: ir←mem_rdata, pc←pc+1, → EXEC. No ack: hold.
- EXEC by opcode (operand address = ir[ADDR_W-1:0]):
  - 0 HLT → HALT.
  - 1 SKZ: if acc==0, pc←pc+1. 2-cycle-free, no mem.
  - 2 ADD: read; {carry,acc}←acc+data (DATA_W+1-bit sum).
  - 3 AND, 4 XOR, 9 OR: read; acc←acc op data; carry unchanged.
  - 5 LDA: read; acc←data; carry unchanged.
  - 6 STO: write acc to operand address.
  - 7 JMP: pc←operand address.
  - 8 SUB: read; acc←acc−data mod 2^DATA_W; carry←(acc<data) unsigned borrow.
  - A SHL: carry←acc[MSB], acc←acc<<1. B SHR (logical): carry←acc[0], acc←acc>>1.
  - C SKC: if carry, pc←pc+1.
  - D–F: NOP.
  - Memory-type EXEC holds with request stable until ack, then → FETCH; non-memory EXEC → FETCH after one cycle.
- HALT: no request; run=1 → FETCH at current pc (already past HLT). run outside HALT ignored.
- pc arithmetic wraps modulo 2^ADDR_W (pc=2^ADDR_W−1 increments/skips to 0).

## Timing
- While rst=0 and in BOOT: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halt=0, pc=0, acc=0, ir=0, carry=0.
- First fetch request in second cycle after rst rises (BOOT occupies one).
- mem_req/mem_we/mem_addr/mem_wdata decode from state+ir; they must not change while mem_req=1 and no ack.
- Zero-wait memory (ack tied 1): memory instruction = 2 cycles, others = 2 cycles, HLT enters HALT 2 cycles after fetch starts. Each wait cycle adds exactly one cycle.
- Back-to-back: mem_req may stay high across EXEC→FETCH; each ack edge retires exactly one transaction.
- run pulse in same cycle HLT executes: ignored (not yet in HALT).
- rst low mid-transaction: transaction abandoned, mem_req drops next edge; memory must tolerate it. A write already acked is not undone.
- acc/carry update on the completing ack edge only.

## Structure
- Package veryrisc_pkg: opcode enum (4 bits, values above), state enum, DATA_W default.
- Sub-module veryrisc_alu_p (combinational: opcode, acc, data, carry_in → result, carry_out, zero), parametrised by DATA_W.
- Core holds FSM, pc, ir, acc, carry registers.

## Test plan
- Reset then ack=1, memory {0:LDA 0x10, 1:ADD 0x11, 2:STO 0x12, 3:HLT}, [0x10]=0x7FF,[0x11]=0x001 → [0x12]=0x800, carry=0, halt=1 after 8 cycles post-BOOT, pc=4.
- Same program, ack asserted only every 3rd cycle → identical results; mem_addr/mem_we stable while req unacked.
- ADD 0xFFF+0x001 → acc=0, carry=1; SKC skips next instruction; SUB 0x000−0x001 → acc=0xFFF, carry=1.
- SKZ with acc=0 at pc=0xFF (ADDR_W=8) → pc wraps to 0x01; JMP 0x40 → next fetch address 0x40.
- HLT then run pulse 5 cycles later → fetch from pc+1; run pulse while running → no effect.
- rst low during a wait-stated FETCH → mem_req=0 next cycle, all registers zero, refetch from 0 after BOOT.

Source files
------------

// File: rtl/veryrisc_pkg.sv
// rtl/veryrisc_pkg.sv - shared opcode/state types and helpers for the VeryRISC accumulator core
package veryrisc_pkg;

   localparam int DATA_W_DEF = 12;

   typedef enum logic [3:0] {
      OP_HLT = 4'h0,
      OP_SKZ = 4'h1,
      OP_ADD = 4'h2,
      OP_AND = 4'h3,
      OP_XOR = 4'h4,
      OP_LDA = 4'h5,
      OP_STO = 4'h6,
      OP_JMP = 4'h7,
      OP_SUB = 4'h8,
      OP_OR  = 4'h9,
      OP_SHL = 4'hA,
      OP_SHR = 4'hB,
      OP_SKC = 4'hC,
      OP_NOP = 4'hD
   } opcode_e;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_FETCH,
      ST_EXEC,
      ST_HALT
   } state_e;

   // Opcodes whose EXEC phase owns a memory transaction.
   function automatic logic is_mem_op(input opcode_e op);
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_OR, OP_LDA, OP_SUB, OP_STO: return 1'b1;
         default:                                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/veryrisc_alu_p.sv
// rtl/veryrisc_alu_p.sv - combinational ALU; passes acc/carry through for non-arithmetic opcodes
module veryrisc_alu_p
   import veryrisc_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] data,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              zero
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   always_comb begin
      sum       = {1'b0, acc} + {1'b0, data};
      diff      = {1'b0, acc} - {1'b0, data};
      result    = acc;
      carry_out = carry_in;
      case (opcode_e'(opcode))
         OP_ADD: {carry_out, result} = sum;
         // The extra diff bit is set exactly when acc < data (unsigned borrow).
         OP_SUB: begin
            result    = diff[DATA_W-1:0];
            carry_out = diff[DATA_W];
         end
         OP_AND: result = acc & data;
         OP_XOR: result = acc ^ data;
         OP_OR:  result = acc | data;
         OP_LDA: result = data;
         OP_SHL: begin
            carry_out = acc[DATA_W-1];
            result    = {acc[DATA_W-2:0], 1'b0};
         end
         OP_SHR: begin
            carry_out = acc[0];
            result    = {1'b0, acc[DATA_W-1:1]};
         end
         default: ;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/veryrisc_core_p.sv
// rtl/veryrisc_core_p.sv - accumulator CPU core: BOOT/FETCH/EXEC/HALT FSM with req/ack memory port
module veryrisc_core_p
   import veryrisc_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   localparam int ADDR_W = DATA_W - 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halt,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              carry_q, carry_d;

   opcode_e           op;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic              alu_zero;

   assign op      = opcode_e'(ir_q[DATA_W-1 -: 4]);
   assign operand = ir_q[ADDR_W-1:0];

   veryrisc_alu_p #(.DATA_W(DATA_W)) u_alu (
      .opcode    (ir_q[DATA_W-1 -: 4]),
      .acc       (acc_q),
      .data      (mem_rdata),
      .carry_in  (carry_q),
      .result    (alu_result),
      .carry_out (alu_carry),
      .zero      (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_BOOT;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         carry_q <= carry_d;
      end
   end

   // Memory port outputs depend only on state and ir, so they stay frozen while a request waits.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_BOOT: state_d = ST_FETCH;
         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_q;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d = ST_FETCH;
            if (!is_mem_op(op) || mem_ack) begin
               acc_d   = alu_result;
               carry_d = alu_carry;
            end
            if (is_mem_op(op)) begin
               mem_req  = 1'b1;
               mem_we   = (op == OP_STO);
               mem_addr = operand;
               if (op == OP_STO) mem_wdata = acc_q;
               if (!mem_ack) state_d = ST_EXEC;
            end
            case (op)
               OP_HLT:  state_d = ST_HALT;
               OP_SKZ:  if (alu_zero) pc_d = pc_q + ADDR_W'(1);
               OP_SKC:  if (carry_q) pc_d = pc_q + ADDR_W'(1);
               OP_JMP:  pc_d = operand;
               default: ;
            endcase
         end
         ST_HALT: if (run) state_d = ST_FETCH;
         default: state_d = ST_BOOT;
      endcase
   end

   assign halt = (state_q == ST_HALT);
   assign pc   = pc_q;
   assign acc  = acc_q;

endmodule

// File: tb/tb_veryrisc_core_p.sv
// tb/tb_veryrisc_core_p.sv - self-checking bench for veryrisc_core_p (DATA_W=12, ADDR_W=8)
module tb_veryrisc_core_p;
   import veryrisc_pkg::*;

   localparam int DATA_W = 12;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              run = 1'b0;
   logic              mem_req, mem_we, mem_ack, halt;
   logic [ADDR_W-1:0] mem_addr, pc;
   logic [DATA_W-1:0] mem_wdata, mem_rdata, acc;

   logic [DATA_W-1:0] mem [0:255];
   int                ack_mode = 1;
   int                tick_cnt = 0;
   logic              ack_tick = 1'b0;
   int                n_chk = 0;
   int                n_fail = 0;
   logic              stab_en = 1'b0;
   logic              pend = 1'b0;
   logic              prev_we = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic [ADDR_W-1:0] acked_log [$];
   int                st_count = 0;
   logic [ADDR_W-1:0] st_addr = '0;
   logic [DATA_W-1:0] st_data = '0;

   typedef struct {
      logic [3:0]  op;
      logic [11:0] a;
      logic [11:0] b;
      logic        cin;
      logic [11:0] exp_acc;
      logic        exp_c;
   } vec_t;

   veryrisc_core_p #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .halt      (halt),
      .pc        (pc),
      .acc       (acc)
   );

   always #5 clk = ~clk;

   // ack_mode: 0 never, 1 always, 2 every third cycle
   assign mem_rdata = mem[mem_addr];
   assign mem_ack   = (ack_mode == 1) || (ack_mode == 2 && ack_tick);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] a);
      return {op, a};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      run = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_until_halt(input int max, output int n);
      n = 0;
      while (!halt && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("halt_reached", halt, 1);
   endtask

   task automatic load_main();
      clear_mem();
      mem[0]     = ins(OP_LDA, 8'h10);
      mem[1]     = ins(OP_ADD, 8'h11);
      mem[2]     = ins(OP_STO, 8'h12);
      mem[3]     = ins(OP_HLT, 8'h00);
      mem[8'h10] = 12'h7FF;
      mem[8'h11] = 12'h001;
   endtask

   // Bus monitor: request stability while unacked, log of completed transactions.
   always @(negedge clk) begin
      tick_cnt = (tick_cnt == 2) ? 0 : tick_cnt + 1;
      ack_tick = (tick_cnt == 0);
      #1;
      if (stab_en && pend && rst) begin
         chk("stable_req", mem_req, 1);
         chk("stable_addr", mem_addr, prev_addr);
         chk("stable_we", mem_we, prev_we);
      end
      pend      = rst && mem_req && !mem_ack;
      prev_addr = mem_addr;
      prev_we   = mem_we;
      if (rst && mem_req && mem_ack) begin
         acked_log.push_back(mem_addr);
         if (mem_we) begin
            st_count++;
            st_addr = mem_addr;
            st_data = mem_wdata;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [17];
      int   n;
      logic [ADDR_W-1:0] exp_log [4];

      vt[0]  = '{OP_ADD, 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
      vt[1]  = '{OP_ADD, 12'h7FF, 12'h001, 1'b1, 12'h800, 1'b0};
      vt[2]  = '{OP_ADD, 12'h001, 12'h002, 1'b1, 12'h003, 1'b0};
      vt[3]  = '{OP_SUB, 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1};
      vt[4]  = '{OP_SUB, 12'h005, 12'h003, 1'b1, 12'h002, 1'b0};
      vt[5]  = '{OP_SUB, 12'h003, 12'h003, 1'b0, 12'h000, 1'b0};
      vt[6]  = '{OP_AND, 12'hF0F, 12'h0FF, 1'b1, 12'h00F, 1'b1};
      vt[7]  = '{OP_XOR, 12'hAAA, 12'hFFF, 1'b0, 12'h555, 1'b0};
      vt[8]  = '{OP_OR,  12'h0A0, 12'h505, 1'b1, 12'h5A5, 1'b1};
      vt[9]  = '{OP_LDA, 12'h111, 12'h123, 1'b0, 12'h123, 1'b0};
      vt[10] = '{OP_SHL, 12'h801, 12'h000, 1'b0, 12'h002, 1'b1};
      vt[11] = '{OP_SHL, 12'h401, 12'h000, 1'b1, 12'h802, 1'b0};
      vt[12] = '{OP_SHR, 12'h803, 12'h000, 1'b0, 12'h401, 1'b1};
      vt[13] = '{OP_SHR, 12'h802, 12'h000, 1'b1, 12'h401, 1'b0};
      vt[14] = '{4'hD,   12'h456, 12'h000, 1'b1, 12'h456, 1'b1};
      vt[15] = '{4'hF,   12'h456, 12'h000, 1'b0, 12'h456, 1'b0};
      vt[16] = '{OP_SKZ, 12'h001, 12'h000, 1'b1, 12'h001, 1'b1};

      // Reset state
      clear_mem();
      ack_mode = 1;
      do_reset();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_halt", halt, 0);
      chk("rst_pc", pc, 0);
      chk("rst_acc", acc, 0);

      // Reference program, zero-wait memory
      load_main();
      st_count = 0;
      rst = 1'b1;
      chk("boot_no_req", mem_req, 0);
      @(negedge clk);
      chk("first_fetch_req", mem_req, 1);
      chk("first_fetch_addr", mem_addr, 0);
      run_until_halt(100, n);
      chk("zero_wait_cycles", n, 8);
      chk("main_acc", acc, 12'h800);
      chk("main_pc", pc, 4);
      chk("main_st_count", st_count, 1);
      chk("main_st_addr", st_addr, 8'h12);
      chk("main_st_data", st_data, 12'h800);

      // Same program with ack every third cycle
      do_reset();
      load_main();
      st_count = 0;
      ack_mode = 2;
      stab_en  = 1'b1;
      rst = 1'b1;
      run_until_halt(300, n);
      stab_en = 1'b0;
      chk("ws_acc", acc, 12'h800);
      chk("ws_pc", pc, 4);
      chk("ws_st_count", st_count, 1);
      chk("ws_st_addr", st_addr, 8'h12);
      chk("ws_st_data", st_data, 12'h800);
      chk("ws_slower", n > 9, 1);

      // ALU vectors; carry observed through SKC (taken -> HLT at 6, pc=7)
      for (int i = 0; i < 17; i++) begin
         do_reset();
         clear_mem();
         mem[0]     = ins(OP_LDA, 8'h22);
         mem[1]     = ins(OP_SHL, 8'h00);
         mem[2]     = ins(OP_LDA, 8'h20);
         mem[3]     = ins(vt[i].op, 8'h21);
         mem[4]     = ins(OP_SKC, 8'h00);
         mem[5]     = ins(OP_HLT, 8'h00);
         mem[6]     = ins(OP_HLT, 8'h00);
         mem[8'h20] = vt[i].a;
         mem[8'h21] = vt[i].b;
         mem[8'h22] = vt[i].cin ? 12'h800 : 12'h000;
         ack_mode   = (i % 2 == 0) ? 1 : 2;
         rst = 1'b1;
         run_until_halt(300, n);
         chk($sformatf("vec%0d_acc", i), acc, vt[i].exp_acc);
         chk($sformatf("vec%0d_carry_pc", i), pc, vt[i].exp_c ? 7 : 6);
      end

      // SKZ wrap at 0xFF, then JMP 0x40
      do_reset();
      clear_mem();
      mem[8'h00] = ins(OP_JMP, 8'hFF);
      mem[8'hFF] = ins(OP_SKZ, 8'h00);
      mem[8'h01] = ins(OP_JMP, 8'h40);
      mem[8'h40] = ins(OP_HLT, 8'h00);
      ack_mode = 1;
      acked_log.delete();
      exp_log = '{8'h00, 8'hFF, 8'h01, 8'h40};
      rst = 1'b1;
      @(negedge clk);
      run_until_halt(100, n);
      chk("skz_cycles", n, 8);
      chk("skz_pc", pc, 8'h41);
      chk("skz_log_size", acked_log.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("skz_fetch%0d", i),
             (i < acked_log.size()) ? acked_log[i] : 8'hxx, exp_log[i]);

      // HLT, run pulses ignored while running, resume after 5 cycles
      do_reset();
      clear_mem();
      mem[0]     = ins(OP_HLT, 8'h00);
      mem[1]     = ins(OP_LDA, 8'h10);
      mem[2]     = ins(OP_HLT, 8'h00);
      mem[8'h10] = 12'h321;
      rst = 1'b1;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("hlt_halt", halt, 1);
      chk("hlt_pc", pc, 1);
      repeat (5) @(negedge clk);
      chk("hlt_still_halt", halt, 1);
      chk("hlt_no_req", mem_req, 0);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      chk("resume_halt", halt, 0);
      chk("resume_req", mem_req, 1);
      chk("resume_addr", mem_addr, 1);
      run_until_halt(100, n);
      chk("resume_acc", acc, 12'h321);
      chk("resume_pc", pc, 3);

      // Reset during a stalled FETCH, then refetch with two wait cycles
      do_reset();
      load_main();
      ack_mode = 1;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      ack_mode = 0;
      repeat (2) @(negedge clk);
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 2);
      chk("stall_acc", acc, 12'h800);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_req", mem_req, 0);
      chk("midrst_we", mem_we, 0);
      chk("midrst_addr", mem_addr, 0);
      chk("midrst_pc", pc, 0);
      chk("midrst_acc", acc, 0);
      chk("midrst_halt", halt, 0);
      st_count = 0;
      rst = 1'b1;
      @(negedge clk);
      chk("refetch_req", mem_req, 1);
      chk("refetch_addr", mem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      ack_mode = 1;
      run_until_halt(100, n);
      chk("wait_total_cycles", n + 3, 11);
      chk("refetch_acc", acc, 12'h800);
      chk("refetch_pc", pc, 4);
      chk("refetch_st_count", st_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
